fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 110 +++++++++++
 tb/tb_fifo_rd_stream.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a show-ahead FIFO into a valid/ready stream
// through a 2-entry skid buffer, counting delivered words.
//
// Ports:
//   rclk, rrst_n          read clock, async active-low reset
//   fifo_rdata/rempty     FIFO head word and empty flag (show-ahead)
//   fifo_rinc             FIFO pop strobe
//   m_data/m_valid        stream output (registered)
//   m_ready               stream back-pressure
//   flush                 discard buffered words
//   xfer_cnt              saturating count of stream handshakes
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] tail;
  logic [DSIZE-1:0] head_nxt;
  logic [DSIZE-1:0] tail_nxt;
  logic             push;
  logic             pop;

  // Pop decision depends only on local state, never on m_ready,
  // so the FIFO never sees a combinational path from the consumer.
  assign fifo_rinc = rrst_n & ~fifo_rempty & (state != TWO) & ~flush;

  assign push    = fifo_rinc;
  assign m_valid = (state != EMPTY);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_nxt  = fifo_rdata;
        end
      end
      ONE: begin
        unique case (1'b1)
          push && !pop: begin
            state_nxt = TWO;
            tail_nxt  = fifo_rdata;
          end
          push && pop: begin
            head_nxt  = fifo_rdata;
          end
          pop && !push: begin
            state_nxt = EMPTY;
          end
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          state_nxt = ONE;
          head_nxt  = tail;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  // A handshake in the flush cycle still counts as delivered.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      xfer_cnt <= '0;
    end else if (pop && (xfer_cnt != '1)) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed scoreboard bench for fifo_rd_stream.
// A queue models the FIFO; popped words feed the expected queue.
module tb_fifo_rd_stream;

  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rempty;
  logic          fifo_rinc;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          flush;
  logic [CW-1:0] xfer_cnt;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int vecs  = 0;
  int miss  = 0;
  int cnt_m = 0;

  fifo_rd_stream #(.DSIZE(DW), .CNT_W(CW)) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .fifo_rinc   (fifo_rinc),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .flush       (flush),
    .xfer_cnt    (xfer_cnt)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    fifo_rempty = (src_q.size() == 0);
    fifo_rdata  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic load(input logic [DW-1:0] w);
    src_q.push_back(w);
    drive_src();
  endtask

  // One clock: check outputs at negedge, advance model after posedge.
  task automatic step();
    logic rinc_e;
    logic hs;
    @(negedge rclk);
    rinc_e = (src_q.size() != 0) && (exp_q.size() < 2) && !flush;
    hs     = (exp_q.size() != 0) && m_ready;
    chk("m_valid", m_valid, exp_q.size() != 0);
    chk("fifo_rinc", fifo_rinc, rinc_e);
    if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
    chk("xfer_cnt", xfer_cnt, cnt_m);
    @(posedge rclk);
    #1;
    if (hs) begin
      void'(exp_q.pop_front());
      if (cnt_m < CMAX) cnt_m++;
    end
    if (flush) exp_q.delete();
    if (rinc_e) exp_q.push_back(src_q.pop_front());
    drive_src();
  endtask

  // Reset asserted mid-cycle; outputs must clear with no clock edge.
  task automatic pulse_reset();
    @(negedge rclk);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_fifo_rinc", fifo_rinc, 0);
    exp_q.delete();
    cnt_m = 0;
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    drive_src();
    #3;
    chk("init_m_valid", m_valid, 0);
    chk("init_xfer_cnt", xfer_cnt, 0);
    chk("init_fifo_rinc", fifo_rinc, 0);
    chk("init_m_data", m_data, 0);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    // Back-to-back stream of three words
    load(8'h11); load(8'h22); load(8'h33);
    m_ready = 1'b1;
    repeat (6) step();
    chk("t1_cnt", xfer_cnt, 3);
    chk("t1_idle", m_valid, 0);

    // Stall for five cycles, then drain
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
    repeat (5) step();
    chk("t2_head", m_data, 8'hA0);
    chk("t2_left", fifo_rempty, 0);
    chk("t2_rdata", fifo_rdata, 8'hA2);
    m_ready = 1'b1;
    repeat (8) step();

    // Toggling back-pressure over six words
    pulse_reset();
    for (int i = 0; i < 6; i++) load(8'hB0 + 8'(i));
    for (int i = 0; i < 14; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    m_ready = 1'b1;
    repeat (3) step();
    chk("t3_cnt", xfer_cnt, 6);

    // Flush with two words buffered and a handshake in flight
    m_ready = 1'b0;
    load(8'h55); load(8'h66);
    repeat (3) step();
    load(8'h77);
    m_ready = 1'b1;
    flush   = 1'b1;
    step();
    flush   = 1'b0;
    chk("t4_valid", m_valid, 0);
    chk("t4_cnt", xfer_cnt, 7);
    repeat (3) step();
    chk("t4_cnt_after", xfer_cnt, 8);

    // Asynchronous reset while two words are buffered
    m_ready = 1'b0;
    load(8'hC0); load(8'hC1);
    repeat (3) step();
    pulse_reset();
    repeat (2) step();

    // Counter saturation on 20 words
    for (int i = 0; i < 20; i++) load(8'(8'hD0 + i));
    m_ready = 1'b1;
    repeat (24) step();
    chk("t6_cnt", xfer_cnt, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
